// File: rtl/bcp_sync_fifo.sv
// bcp_sync_fifo: synchronous FIFO between the clause evaluator and the
// propagation controller. Gray-free binary pointers with one extra wrap bit,
// optional first-word-fall-through read port, synchronous flush used on
// conflict, and sticky overflow/underflow flags.
module bcp_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG  = 3,
   parameter int AFULL_LVL  = 7,
   parameter int AEMPTY_LVL = 1,
   parameter int FWFT       = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 flush,
   input  logic                 wr_en,
   input  logic [DATA_W-1:0]    wr_data,
   input  logic                 rd_en,
   output logic [DATA_W-1:0]    rd_data,
   output logic                 rd_valid,
   output logic [DEPTH_LOG:0]   count,
   output logic                 full,
   output logic                 empty,
   output logic                 afull,
   output logic                 aempty,
   output logic                 overflow,
   output logic                 underflow,
   input  logic                 clr_err
);

   localparam int PW    = DEPTH_LOG + 1;
   localparam int DEPTH = 1 << DEPTH_LOG;

   localparam logic [PW-1:0] DEPTH_C  = PW'(DEPTH);
   localparam logic [PW-1:0] AFULL_C  = PW'(AFULL_LVL);
   localparam logic [PW-1:0] AEMPTY_C = PW'(AEMPTY_LVL);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [PW-1:0] wptr_q, wptr_d;
   logic [PW-1:0] rptr_q, rptr_d;
   logic          ovf_q, ovf_d;
   logic          unf_q, unf_d;
   logic          wr_acc, rd_acc;
   logic          ovf_set, unf_set;

   // Occupancy and flags come only from registered pointers, so there is no
   // combinational path from the request inputs to any status output.
   assign count  = wptr_q - rptr_q;
   assign full   = (count == DEPTH_C);
   assign empty  = (count == '0);
   assign afull  = (count >= AFULL_C);
   assign aempty = (count <= AEMPTY_C);

   assign overflow  = ovf_q;
   assign underflow = unf_q;

   // Acceptance, error detection and next-state pointers; flush overrides all.
   always_comb begin
      wr_acc  = wr_en && !full  && !flush;
      rd_acc  = rd_en && !empty && !flush;
      ovf_set = wr_en && full  && !flush;
      unf_set = rd_en && empty && !flush;
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      if (flush) begin
         wptr_d = '0;
         rptr_d = '0;
      end else begin
         if (wr_acc) wptr_d = wptr_q + PW'(1);
         if (rd_acc) rptr_d = rptr_q + PW'(1);
      end
      // set beats clear when both happen in the same cycle
      ovf_d = ovf_set || (ovf_q && !clr_err);
      unf_d = unf_set || (unf_q && !clr_err);
   end

   // Pointer and sticky-flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wptr_q <= '0;
         rptr_q <= '0;
         ovf_q  <= 1'b0;
         unf_q  <= 1'b0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         ovf_q  <= ovf_d;
         unf_q  <= unf_d;
      end
   end

   // Storage array; deliberately not reset.
   always_ff @(posedge clock) begin
      if (wr_acc) mem_q[wptr_q[DEPTH_LOG-1:0]] <= wr_data;
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head entry is presented combinationally; zero while empty.
         assign rd_valid = !empty;
         assign rd_data  = empty ? '0 : mem_q[rptr_q[DEPTH_LOG-1:0]];
      end else begin : g_reg
         logic [DATA_W-1:0] rd_data_q;
         logic              rd_valid_q;

         // Registered read: data and qualifier appear one edge after the pop.
         always_ff @(posedge clock or negedge reset) begin
            if (!reset) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else if (flush) begin
               rd_data_q  <= '0;
               rd_valid_q <= 1'b0;
            end else if (rd_acc) begin
               rd_data_q  <= mem_q[rptr_q[DEPTH_LOG-1:0]];
               rd_valid_q <= 1'b1;
            end else begin
               rd_valid_q <= 1'b0;
            end
         end

         assign rd_data  = rd_data_q;
         assign rd_valid = rd_valid_q;
      end
   endgenerate

endmodule

// File: tb/tb_bcp_sync_fifo.sv
// Bench for bcp_sync_fifo: a registered-read instance checked through a
// reference queue + scoreboard monitor, and a fall-through instance checked
// with directed values including an asynchronous reset mid-burst.
module tb_bcp_sync_fifo;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   // registered-read instance
   logic       d_rst_b, d_flush, d_wr_en, d_rd_en, d_clr_err;
   logic [7:0] d_wr_data, d_rd_data;
   logic       d_rd_valid, d_full, d_empty, d_afull, d_aempty, d_ovf, d_unf;
   logic [3:0] d_count;

   // fall-through instance
   logic       f_rst_b, f_flush, f_wr_en, f_rd_en, f_clr_err;
   logic [7:0] f_wr_data, f_rd_data;
   logic       f_rd_valid, f_full, f_empty, f_afull, f_aempty, f_ovf, f_unf;
   logic [3:0] f_count;

   bcp_sync_fifo #(.DATA_W(8), .DEPTH_LOG(3), .AFULL_LVL(7), .AEMPTY_LVL(1), .FWFT(0)) dut (
      .clock(clk), .reset(d_rst_b), .flush(d_flush), .wr_en(d_wr_en), .wr_data(d_wr_data),
      .rd_en(d_rd_en), .rd_data(d_rd_data), .rd_valid(d_rd_valid), .count(d_count),
      .full(d_full), .empty(d_empty), .afull(d_afull), .aempty(d_aempty),
      .overflow(d_ovf), .underflow(d_unf), .clr_err(d_clr_err));

   bcp_sync_fifo #(.DATA_W(8), .DEPTH_LOG(3), .AFULL_LVL(7), .AEMPTY_LVL(1), .FWFT(1)) dut_f (
      .clock(clk), .reset(f_rst_b), .flush(f_flush), .wr_en(f_wr_en), .wr_data(f_wr_data),
      .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .count(f_count),
      .full(f_full), .empty(f_empty), .afull(f_afull), .aempty(f_aempty),
      .overflow(f_ovf), .underflow(f_unf), .clr_err(f_clr_err));

   logic [7:0] mdl[$];    // reference contents
   logic [7:0] exp_q[$];  // scoreboard: expected read data in order

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for the registered-read instance.
   always @(negedge clk) begin
      if (d_rd_valid === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_read: got %0h expected none", d_rd_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (d_rd_data !== e) begin
               n_fail++;
               $display("FAIL read_data: got %0h expected %0h", d_rd_data, e);
            end
         end
      end
   end

   // One clock of stimulus on the registered-read instance; updates the model.
   task automatic cyc(input bit we, input logic [7:0] wd, input bit re, input bit fl, input bit ce);
      bit m_full, m_empty;
      d_wr_en = we; d_wr_data = wd; d_rd_en = re; d_flush = fl; d_clr_err = ce;
      m_full  = (mdl.size() == 8);
      m_empty = (mdl.size() == 0);
      @(posedge clk); #1;
      if (fl) mdl.delete();
      else begin
         if (re && !m_empty) exp_q.push_back(mdl.pop_front());
         if (we && !m_full) mdl.push_back(wd);
      end
      d_wr_en = 1'b0; d_rd_en = 1'b0; d_flush = 1'b0; d_clr_err = 1'b0;
   endtask

   task automatic fcyc(input bit we, input logic [7:0] wd, input bit re);
      f_wr_en = we; f_wr_data = wd; f_rd_en = re;
      @(posedge clk); #1;
      f_wr_en = 1'b0; f_rd_en = 1'b0;
   endtask

   initial begin
      d_rst_b = 1'b0; d_flush = 1'b0; d_wr_en = 1'b0; d_rd_en = 1'b0; d_clr_err = 1'b0; d_wr_data = '0;
      f_rst_b = 1'b0; f_flush = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_count", d_count, 0);
      chk("rst_empty", d_empty, 1);
      chk("rst_full", d_full, 0);
      chk("rst_aempty", d_aempty, 1);
      chk("rst_afull", d_afull, 0);
      chk("rst_rd_valid", d_rd_valid, 0);
      chk("rst_rd_data", d_rd_data, 0);
      chk("rst_ovf", d_ovf, 0);
      chk("rst_unf", d_unf, 0);
      @(negedge clk);
      d_rst_b = 1'b1; f_rst_b = 1'b1;
      @(posedge clk); #1;

      // 1: fill, overflow, drain in order
      for (int i = 1; i <= 8; i++) begin
         cyc(1, 8'(i), 0, 0, 0);
         chk("t1_count", d_count, i);
         chk("t1_afull", d_afull, (i >= 7));
         chk("t1_full", d_full, (i == 8));
         chk("t1_aempty", d_aempty, (i <= 1));
      end
      cyc(1, 8'hFF, 0, 0, 0);
      chk("t1_ovf", d_ovf, 1);
      chk("t1_count_after_ovf", d_count, 8);
      for (int i = 7; i >= 0; i--) begin
         cyc(0, 8'h00, 1, 0, 0);
         chk("t1_drain_count", d_count, i);
      end
      cyc(0, 8'h00, 0, 0, 1);
      chk("t1_ovf_cleared", d_ovf, 0);
      chk("t1_empty", d_empty, 1);
      chk("t1_sb_drained", exp_q.size(), 0);

      // 2: drain past empty, underflow
      cyc(1, 8'hA5, 0, 0, 0);
      cyc(1, 8'h5A, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("t2_valid1", d_rd_valid, 1);
      cyc(0, 8'h00, 1, 0, 0);
      chk("t2_valid2", d_rd_valid, 1);
      chk("t2_unf_not_yet", d_unf, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("t2_valid_low", d_rd_valid, 0);
      chk("t2_unf", d_unf, 1);
      chk("t2_empty", d_empty, 1);
      cyc(0, 8'h00, 0, 0, 1);
      chk("t2_unf_cleared", d_unf, 0);

      // 3: steady read+write at count 3, pointers wrap
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h20 + i), 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 8'(8'h23 + i), 1, 0, 0);
         chk("t3_count", d_count, 3);
         chk("t3_full", d_full, 0);
         chk("t3_empty", d_empty, 0);
      end
      for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 0);
      chk("t3_sb_drained", exp_q.size(), 0);

      // 4: read and write together at full
      for (int i = 0; i < 8; i++) cyc(1, 8'(8'h40 + i), 0, 0, 0);
      chk("t4_full", d_full, 1);
      cyc(1, 8'hEE, 1, 0, 0);
      chk("t4_count", d_count, 7);
      chk("t4_ovf", d_ovf, 1);
      for (int i = 0; i < 7; i++) cyc(0, 8'h00, 1, 0, 0);
      cyc(0, 8'h00, 0, 0, 1);
      chk("t4_sb_drained", exp_q.size(), 0);
      chk("t4_ovf_cleared", d_ovf, 0);

      // 5: flush with requests in the same cycle
      for (int i = 0; i < 5; i++) cyc(1, 8'(8'h50 + i), 0, 0, 0);
      chk("t5_count_pre", d_count, 5);
      chk("t5_rd_data_pre", d_rd_data, 8'h47);
      cyc(1, 8'h99, 1, 1, 0);
      chk("t5_count", d_count, 0);
      chk("t5_empty", d_empty, 1);
      chk("t5_rd_valid", d_rd_valid, 0);
      chk("t5_rd_data", d_rd_data, 0);
      chk("t5_ovf", d_ovf, 0);
      chk("t5_unf", d_unf, 0);
      cyc(1, 8'h3C, 0, 0, 0);
      cyc(0, 8'h00, 1, 0, 0);
      chk("t5_first_after_flush", d_rd_data, 8'h3C);
      cyc(0, 8'h00, 0, 0, 0);
      chk("t5_sb_drained", exp_q.size(), 0);

      // 6: fall-through mode and asynchronous reset
      fcyc(1, 8'h11, 0);
      chk("t6_valid", f_rd_valid, 1);
      chk("t6_data", f_rd_data, 8'h11);
      fcyc(0, 8'h00, 1);
      chk("t6_pop_valid", f_rd_valid, 0);
      chk("t6_pop_data", f_rd_data, 0);
      fcyc(0, 8'h00, 1);
      chk("t6_unf", f_unf, 1);
      fcyc(1, 8'h22, 0);
      fcyc(1, 8'h33, 0);
      chk("t6_head", f_rd_data, 8'h22);
      fcyc(1, 8'h44, 1);
      chk("t6_next_head", f_rd_data, 8'h33);
      chk("t6_count", f_count, 2);
      f_wr_en = 1'b1; f_wr_data = 8'h55;
      #3;
      f_rst_b = 1'b0;
      #1;
      chk("t6_rst_valid", f_rd_valid, 0);
      chk("t6_rst_data", f_rd_data, 0);
      chk("t6_rst_count", f_count, 0);
      chk("t6_rst_empty", f_empty, 1);
      chk("t6_rst_full", f_full, 0);
      chk("t6_rst_aempty", f_aempty, 1);
      chk("t6_rst_afull", f_afull, 0);
      chk("t6_rst_unf", f_unf, 0);
      chk("t6_rst_ovf", f_ovf, 0);
      f_wr_en = 1'b0;
      @(negedge clk);
      f_rst_b = 1'b1;
      repeat (2) @(posedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/bcp_sync_fifo.md
# bcp_sync_fifo

Parametrised synchronous FIFO for the hardware BCP datapath. It is the next generation of the implication/clause-index queue. It adds:
- configurable width and depth
- true simultaneous read and write
- a first-word-fall-through (FWFT) mode
- almost-full/almost-empty thresholds
- a synchronous flush, used on conflict to discard pending implications
- sticky overflow/underflow error flags

It sits between the clause evaluator (producer) and the assignment/propagation controller (consumer).

## Interface
Parameters:
- DATA_W, 8, entry width in bits
- DEPTH_LOG, 3, log2 of depth; DEPTH = 2^DEPTH_LOG entries
- AFULL_LVL, 7, afull asserted when count >= AFULL_LVL
- AEMPTY_LVL, 1, aempty asserted when count <= AEMPTY_LVL
- FWFT, 0, 0 = registered-read mode, 1 = first-word-fall-through mode

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low
- flush  in  1  synchronous clear of contents
- wr_en  in  1  write request
- wr_data  in  DATA_W  write data
- rd_en  in  1  read request (pop in FWFT mode)
- rd_data  out  DATA_W  read data
- rd_valid  out  1  rd_data qualifier
- count  out  DEPTH_LOG+1  current occupancy, 0..DEPTH
- full, empty, afull, aempty  out  1  each  status flags
- overflow, underflow  out  1  each  sticky error flags
- clr_err  in  1  clears sticky flags

## Operation
- **Storage:** DEPTH x DATA_W array, not reset. Write and read pointers are DEPTH_LOG+1 bits and wrap modulo 2^(DEPTH_LOG+1). The array is indexed by the low DEPTH_LOG bits.
- **count:** wptr - rptr, truncated to DEPTH_LOG+1 bits.
- **Flags:**
  - full = (count == DEPTH)
  - empty = (count == 0)
  - afull = (count >= AFULL_LVL)
  - aempty = (count <= AEMPTY_LVL)
  - All are derived from the registered pointers only.
- **Write acceptance:** wr_en && !full && !flush. Stores wr_data at wptr and increments wptr.
- **Read acceptance:** rd_en && !empty && !flush. Increments rptr.
- **Simultaneous accepted read and write:** both pointers advance and count is unchanged. A write at full is not accepted in the same cycle as a read, even if a read is accepted.
- **Rejected accesses:**
  - wr_en while full (and no flush): data dropped, overflow set.
  - rd_en while empty (and no flush): pointers unchanged, underflow set.
- **FWFT=0 (registered-read mode):** on an accepted read, rd_data <= mem[rptr] and rd_valid <= 1 at that edge. Otherwise rd_valid <= 0 and rd_data holds its value.
- **FWFT=1 (fall-through mode):**
  - rd_valid = !empty.
  - rd_data = mem[rptr] when !empty, 0 when empty.
  - rd_en pops the head entry; the next entry is presented in the following cycle.
- **flush:** highest priority among synchronous events. At the edge: both pointers <= 0, rd_valid <= 0, rd_data <= 0. wr_en/rd_en in the same cycle are ignored and raise no error flags. Sticky flags are unaffected.
- **Sticky flags:** clr_err clears overflow/underflow at the edge. If a new error event occurs in the same cycle, set wins.
- **Reset (asynchronous, any time, including mid-transfer):**
  - Pointers: 0.
  - rd_data = 0, rd_valid = 0, count = 0.
  - empty = 1, full = 0, aempty = 1, afull = (AFULL_LVL == 0).
  - overflow = 0, underflow = 0.

## Timing
- Write to visible occupancy: count and flags update one cycle after the accepting edge.
- Write to readable data:
  - FWFT=1, empty FIFO: the written entry appears on rd_data with rd_valid=1 in the cycle after the write edge.
  - FWFT=0: rd_en may be accepted in that cycle, and the data appears one cycle later.
- Read latency: FWFT=0 gives data and rd_valid one cycle after rd_en is sampled. FWFT=1 gives data combinationally.
- Full throughput: one write and one read per cycle indefinitely when neither full nor empty.
- No combinational path from wr_en/rd_en to any flag or to count.

## Test plan
Defaults unless stated: DATA_W=8, DEPTH_LOG=3.

1. **Fill and overflow:** write 0x01..0x08 on consecutive cycles, then a 9th write of 0xFF. Required: count=8, full=1, afull=1 after the 7th write, overflow=1. A subsequent drain returns 0x01..0x08 in order, and 0xFF is never read.
2. **Drain and underflow (FWFT=0):** with 2 entries 0xA5, 0x5A, issue 3 consecutive rd_en. Required: rd_data=0xA5 then 0x5A with rd_valid=1 on those two cycles, then rd_valid=0, underflow=1, empty=1. clr_err the next cycle gives underflow=0.
3. **Simultaneous read and write at count=3 for 20 cycles:** count stays 3 and data order is preserved. Pointers wrap past 15 with no glitch on full or empty.
4. **Full with rd_en and wr_en together:** read is accepted, write is rejected, overflow=1, count goes 8 -> 7.
5. **Flush with 5 entries, wr_en=1 and rd_en=1 in the same cycle:** next cycle count=0, empty=1, rd_valid=0, rd_data=0, no error flag set. The next write of 0x3C is read back first.
6. **FWFT=1:** write 0x11 into an empty FIFO. Next cycle rd_valid=1, rd_data=0x11. Pop gives rd_valid=0, rd_data=0. Then assert reset mid-burst: all outputs return to their reset values immediately, without waiting for a clock edge.
